// File: rtl/regfile_2r1w.sv
// Two-read, one-write flop-based register file with registered read ports.
// Optional same-edge write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_2r1w #(
   parameter int WIDTH    = 16,
   parameter int DEPTH    = 16,
   parameter int ZERO_REG = 1
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_re,
   input  logic [$clog2(DEPTH)-1:0]   i_rs1_addr,
   input  logic [$clog2(DEPTH)-1:0]   i_rs2_addr,
   output logic [WIDTH-1:0]           o_rs1_data,
   output logic [WIDTH-1:0]           o_rs2_data,
   output logic                       o_rs_valid,
   input  logic                       i_we,
   input  logic [$clog2(DEPTH)-1:0]   i_rd_addr,
   input  logic [WIDTH-1:0]           i_rd_data
);

   localparam int AW = $clog2(DEPTH);
   // One extra bit so the range compare never degenerates for power-of-two DEPTH.
   localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rs1_data;
   logic [WIDTH-1:0] r_rs2_data;
   logic             r_rs_valid;

   logic             w_wr_ok;
   logic [WIDTH-1:0] w_rs1_nxt;
   logic [WIDTH-1:0] w_rs2_nxt;

   function automatic logic f_in_range(input logic [AW-1:0] addr);
      return ({1'b0, addr} < LP_DEPTH);
   endfunction

   function automatic logic f_is_zero_reg(input logic [AW-1:0] addr);
      return (ZERO_REG != 0) && (addr == '0);
   endfunction

   function automatic logic [WIDTH-1:0] f_read(input logic [AW-1:0] addr);
      logic [WIDTH-1:0] v;
      v = '0;
      if (f_in_range(addr) && !f_is_zero_reg(addr))
         v = r_mem[addr];
      return v;
   endfunction

   assign w_wr_ok = i_we && f_in_range(i_rd_addr) && !f_is_zero_reg(i_rd_addr);

   always_comb begin
      w_rs1_nxt = f_read(i_rs1_addr);
      w_rs2_nxt = f_read(i_rs2_addr);
`ifdef REGFILE_BYPASS_EN
      // w_wr_ok already excludes zero-reg and out-of-range targets, so they win over forwarding.
      if (w_wr_ok && (i_rs1_addr == i_rd_addr))
         w_rs1_nxt = i_rd_data;
      if (w_wr_ok && (i_rs2_addr == i_rd_addr))
         w_rs2_nxt = i_rd_data;
`endif
   end

   // Storage
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++)
            r_mem[i] <= '0;
      end else if (w_wr_ok) begin
         r_mem[i_rd_addr] <= i_rd_data;
      end
   end

   // Read output registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rs1_data <= '0;
         r_rs2_data <= '0;
         r_rs_valid <= 1'b0;
      end else begin
         r_rs_valid <= i_re;
         if (i_re) begin
            r_rs1_data <= w_rs1_nxt;
            r_rs2_data <= w_rs2_nxt;
         end
      end
   end

   assign o_rs1_data = r_rs1_data;
   assign o_rs2_data = r_rs2_data;
   assign o_rs_valid = r_rs_valid;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Scoreboard bench for regfile_2r1w: three instances (16x16 zero-reg, 16x16 plain, 8x12 zero-reg)
// share one stimulus stream; each read pushes hand-computed results, monitors pop on rs_valid.
module tb_regfile_2r1w;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, re, we;
   logic [3:0]  rs1_addr, rs2_addr, rd_addr;
   logic [15:0] rd_data;
   logic [15:0] a_rs1, a_rs2, b_rs1, b_rs2;
   logic [7:0]  c_rs1, c_rs2;
   logic        a_vld, b_vld, c_vld;

   int n_checks = 0;
   int n_errs   = 0;
   logic [31:0] q_a[$];
   logic [31:0] q_b[$];
   logic [31:0] q_c[$];
   logic [31:0] e_a, e_b, e_c;
   logic [31:0] ex_a, ex_b, ex_c;

   regfile_2r1w #(.WIDTH(16), .DEPTH(16), .ZERO_REG(1)) u_a (
      .i_clk(clk), .i_rst(rst), .i_re(re), .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr),
      .o_rs1_data(a_rs1), .o_rs2_data(a_rs2), .o_rs_valid(a_vld),
      .i_we(we), .i_rd_addr(rd_addr), .i_rd_data(rd_data));

   regfile_2r1w #(.WIDTH(16), .DEPTH(16), .ZERO_REG(0)) u_b (
      .i_clk(clk), .i_rst(rst), .i_re(re), .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr),
      .o_rs1_data(b_rs1), .o_rs2_data(b_rs2), .o_rs_valid(b_vld),
      .i_we(we), .i_rd_addr(rd_addr), .i_rd_data(rd_data));

   regfile_2r1w #(.WIDTH(8), .DEPTH(12), .ZERO_REG(1)) u_c (
      .i_clk(clk), .i_rst(rst), .i_re(re), .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr),
      .o_rs1_data(c_rs1), .o_rs2_data(c_rs2), .o_rs_valid(c_vld),
      .i_we(we), .i_rd_addr(rd_addr), .i_rd_data(rd_data[7:0]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name);
      n_checks++;
      n_errs++;
      $display("FAIL %s: rs_valid high with no read outstanding", name);
   endtask

   // Monitors: compare whenever a DUT presents read data.
   always @(negedge clk) begin
      if (a_vld === 1'b1) begin
         if (q_a.size() == 0) unexpected("a_valid");
         else begin
            e_a = q_a.pop_front();
            chk("a_rs1", {16'h0, a_rs1}, {16'h0, e_a[31:16]});
            chk("a_rs2", {16'h0, a_rs2}, {16'h0, e_a[15:0]});
         end
      end
   end

   always @(negedge clk) begin
      if (b_vld === 1'b1) begin
         if (q_b.size() == 0) unexpected("b_valid");
         else begin
            e_b = q_b.pop_front();
            chk("b_rs1", {16'h0, b_rs1}, {16'h0, e_b[31:16]});
            chk("b_rs2", {16'h0, b_rs2}, {16'h0, e_b[15:0]});
         end
      end
   end

   always @(negedge clk) begin
      if (c_vld === 1'b1) begin
         if (q_c.size() == 0) unexpected("c_valid");
         else begin
            e_c = q_c.pop_front();
            chk("c_rs1", {24'h0, c_rs1}, {16'h0, e_c[31:16]});
            chk("c_rs2", {24'h0, c_rs2}, {16'h0, e_c[15:0]});
         end
      end
   end

   task automatic push(input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] ec);
      q_a.push_back(ea);
      q_b.push_back(eb);
      q_c.push_back(ec);
   endtask

   task automatic idle();
      @(negedge clk);
      re = 1'b0;
      we = 1'b0;
   endtask

   task automatic wr(input logic [3:0] a, input logic [15:0] d);
      @(negedge clk);
      re = 1'b0;
      we = 1'b1;
      rd_addr = a;
      rd_data = d;
   endtask

   task automatic rd(input logic [3:0] a1, input logic [3:0] a2,
                     input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] ec);
      @(negedge clk);
      we = 1'b0;
      re = 1'b1;
      rs1_addr = a1;
      rs2_addr = a2;
      push(ea, eb, ec);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_a_rs1"}, {16'h0, a_rs1}, 32'h0);
      chk({tag, "_a_rs2"}, {16'h0, a_rs2}, 32'h0);
      chk({tag, "_a_vld"}, {31'h0, a_vld}, 32'h0);
      chk({tag, "_b_rs1"}, {16'h0, b_rs1}, 32'h0);
      chk({tag, "_b_rs2"}, {16'h0, b_rs2}, 32'h0);
      chk({tag, "_b_vld"}, {31'h0, b_vld}, 32'h0);
      chk({tag, "_c_rs1"}, {24'h0, c_rs1}, 32'h0);
      chk({tag, "_c_rs2"}, {24'h0, c_rs2}, 32'h0);
      chk({tag, "_c_vld"}, {31'h0, c_vld}, 32'h0);
   endtask

   task automatic chk_vld_low(input string tag);
      chk({tag, "_a_vld"}, {31'h0, a_vld}, 32'h0);
      chk({tag, "_b_vld"}, {31'h0, b_vld}, 32'h0);
      chk({tag, "_c_vld"}, {31'h0, c_vld}, 32'h0);
   endtask

   initial begin
      rst = 1'b1; re = 1'b0; we = 1'b0;
      rs1_addr = '0; rs2_addr = '0; rd_addr = '0; rd_data = '0;
      #1;
      chk_all_zero("por");
      @(negedge clk);
      rst = 1'b0;

      // Preload r1..r15, read back, then asynchronous reset between edges.
      for (int i = 1; i < 16; i++) wr(4'(i), 16'h1000 + 16'(i));
      rd(4'd5, 4'd9, 32'h1005_1009, 32'h1005_1009, 32'h0005_0009);
      idle();
      #2;
      rst = 1'b1;
      q_a.delete(); q_b.delete(); q_c.delete();
      #1;
      chk_all_zero("async_rst");
      @(negedge clk);
      rst = 1'b0;
      rd(4'd5, 4'd9, 32'h0, 32'h0, 32'h0);
      idle();
      idle();
      chk_vld_low("post_rst_pulse");

      // Basic write/read and hold with re=0.
      wr(4'd3, 16'hBEEF);
      wr(4'd7, 16'h1234);
      rd(4'd3, 4'd7, 32'hBEEF_1234, 32'hBEEF_1234, 32'h00EF_0034);
      idle();
      idle();
      chk_vld_low("hold");
      chk("hold_a_rs1", {16'h0, a_rs1}, 32'h0000_BEEF);
      chk("hold_a_rs2", {16'h0, a_rs2}, 32'h0000_1234);
      chk("hold_c_rs1", {24'h0, c_rs1}, 32'h0000_00EF);

      // Zero register.
      wr(4'd0, 16'hFFFF);
      rd(4'd0, 4'd0, 32'h0, 32'hFFFF_FFFF, 32'h0);

      // Same-edge collision on r4.
      wr(4'd4, 16'h0011);
`ifdef REGFILE_BYPASS_EN
      ex_a = 32'h00AA_BEEF; ex_b = 32'h00AA_BEEF; ex_c = 32'h00AA_00EF;
`else
      ex_a = 32'h0011_BEEF; ex_b = 32'h0011_BEEF; ex_c = 32'h0011_00EF;
`endif
      @(negedge clk);
      we = 1'b1; rd_addr = 4'd4; rd_data = 16'h00AA;
      re = 1'b1; rs1_addr = 4'd4; rs2_addr = 4'd3;
      push(ex_a, ex_b, ex_c);
      rd(4'd4, 4'd4, 32'h00AA_00AA, 32'h00AA_00AA, 32'h00AA_00AA);

      // Same-edge collision on r0: zero-register rule beats forwarding.
`ifdef REGFILE_BYPASS_EN
      ex_b = 32'h1111_1111;
`else
      ex_b = 32'hFFFF_FFFF;
`endif
      @(negedge clk);
      we = 1'b1; rd_addr = 4'd0; rd_data = 16'h1111;
      re = 1'b1; rs1_addr = 4'd0; rs2_addr = 4'd0;
      push(32'h0, ex_b, 32'h0);

      // Out-of-range writes/reads on the 12-deep instance; back-to-back reads.
      wr(4'd11, 16'h005A);
      wr(4'd14, 16'h0077);
      wr(4'd15, 16'h00C3);
      rd(4'd11, 4'd14, 32'h005A_0077, 32'h005A_0077, 32'h005A_0000);
      rd(4'd15, 4'd13, 32'h00C3_0000, 32'h00C3_0000, 32'h0);
      rd(4'd3,  4'd7,  32'hBEEF_1234, 32'hBEEF_1234, 32'h00EF_0034);
      rd(4'd1,  4'd2,  32'h0, 32'h0, 32'h0);
      rd(4'd4,  4'd0,  32'h00AA_0000, 32'h00AA_1111, 32'h00AA_0000);
      idle();

      // Reset in the middle of continuous read/write traffic.
      @(negedge clk);
      we = 1'b1; rd_addr = 4'd8; rd_data = 16'h8888;
      re = 1'b1; rs1_addr = 4'd3; rs2_addr = 4'd7;
      push(32'hBEEF_1234, 32'hBEEF_1234, 32'h00EF_0034);
      @(negedge clk);
      we = 1'b1; rd_addr = 4'd5; rd_data = 16'h5555;
      re = 1'b1; rs1_addr = 4'd8; rs2_addr = 4'd4;
      #2;
      rst = 1'b1;
      q_a.delete(); q_b.delete(); q_c.delete();
      #1;
      chk_all_zero("midstream_rst");
      @(negedge clk);
      rst = 1'b0; we = 1'b0; re = 1'b0;
      rd(4'd5, 4'd8, 32'h0, 32'h0, 32'h0);
      idle();
      idle();

      chk("a_queue_drained", q_a.size(), 32'd0);
      chk("b_queue_drained", q_b.size(), 32'd0);
      chk("c_queue_drained", q_c.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule

// File: doc/regfile_2r1w.md
# regfile_2r1w

Parametrised general-purpose register file for the 16-bit CPU. It is the next generation of the single-port 16:1 read-select mux and replaces it. The block holds DEPTH registers of WIDTH bits and provides two independent registered read ports (rs1, rs2) and one synchronous write port (rd). It sits between the decode stage, which supplies the addresses, and the ALU operand latches.

## Interface
- WIDTH, 16, register and data width in bits (≥1).
- DEPTH, 16, number of registers (2..256); AW = $clog2(DEPTH) is a derived localparam, not overridable.
- ZERO_REG, 1, when 1 register 0 always reads 0 and ignores writes; when 0 it is a normal register.

- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- re  in  1  read enable; samples both read addresses this cycle.
- rs1_addr  in  AW  read port 1 address.
- rs2_addr  in  AW  read port 2 address.
- rs1_data  out  WIDTH  registered read data, port 1.
- rs2_data  out  WIDTH  registered read data, port 2.
- rs_valid  out  1  one-cycle pulse: rs1_data/rs2_data were updated by the previous re.
- we  in  1  write enable.
- rd_addr  in  AW  write address.
- rd_data  in  WIDTH  write data.

## Operation
- Storage: DEPTH × WIDTH flops. No RAM inference is required.
- Write: at a clock edge with we=1, mem[rd_addr] ← rd_data. The write is ignored if:
  - rd_addr ≥ DEPTH (non-power-of-two DEPTH), or
  - ZERO_REG=1 and rd_addr=0.
- Read: at a clock edge with re=1:
  - rsN_data ← mem[rsN_addr] for each port independently.
  - rs_valid ← 1.
- With re=0, rs_valid ← 0 and rsN_data holds its last value.
- Addresses ≥ DEPTH read as 0.
- With ZERO_REG=1, address 0 reads as 0 regardless of stored contents.
- Both ports may address the same register; both then return identical data.
- No state machine beyond the storage and the output registers. The block never stalls and has no back-pressure.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert): on rst=1, immediately and regardless of clk:
  - all mem entries = 0
  - rs1_data = 0, rs2_data = 0, rs_valid = 0
- Reset asserted mid-operation discards any write or read in that cycle.
- Read latency: address is sampled at edge N; data and rs_valid=1 are visible after edge N, for exactly the cycle N..N+1 (rs_valid) or until the next re (data).
- Write latency: the value is visible to a read sampled at edge N+1 or later.
- Same-edge read and write to the same address: behaviour is set by the Configuration section.
- Back-to-back re every cycle is allowed; rs_valid then stays high continuously.
- Zero register and out-of-range rules take priority over bypass.

## Configuration
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding. If re=1 and we=1 on the same edge and rsN_addr == rd_addr (valid, writable address), rsN_data ← rd_data, the new value. Zero-latency read-after-write, for use in a 2-stage pipeline without a stall.
- Undefined: no forwarding. A same-edge read returns the old mem contents, and the new value is visible from the next read. The forwarding comparators and muxes must not be synthesised.

## Test plan
- Reset: preload registers 1–15 with nonzero values, assert rst between edges → all outputs 0 with no clock edge; after release, re with rs1=5, rs2=9 → both 0x0000, rs_valid=1 for one cycle.
- Basic R/W: write 0xBEEF to r3, then 0x1234 to r7; then re with rs1=3, rs2=7 → next cycle rs1_data=0xBEEF, rs2_data=0x1234, rs_valid=1; following cycle re=0 → rs_valid=0, data held.
- Zero register (ZERO_REG=1): write 0xFFFF to r0, read rs1=rs2=0 → both 0x0000. With ZERO_REG=0 the same sequence → 0xFFFF.
- Same-edge collision: r4=0x0011, then in one cycle we=1 (r4 ← 0x00AA) and re=1 (rs1=4) → 0x00AA with REGFILE_BYPASS_EN, 0x0011 without; next read → 0x00AA in both builds.
- Parameter sweep: WIDTH=8, DEPTH=12: write 0x5A to r11 and 0x77 to address 14 → read r11 returns 0x5A, address 14 returns 0x00, and no other register changes.
- Async reset mid-stream: continuous re/we traffic, rst pulse asserted off-edge → outputs clear within the same cycle, and the write in flight is not committed.
